// File: rtl/serial_parity_pkg.sv
// Shared definitions for the parity-protected serial link: receiver FSM states,
// parity sense constants, frame-field order and parity helper functions.
package serial_parity_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DATA      = 3'd1,
        ST_PARITY    = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    // Order in which fields appear on the line; the transmitter walks the same sequence.
    typedef enum logic [1:0] {
        FIELD_START  = 2'd0,
        FIELD_DATA   = 2'd1,
        FIELD_PARITY = 2'd2,
        FIELD_STOP   = 2'd3
    } frame_field_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    function automatic logic xor_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    // A frame is good when the XOR over data and parity equals the selected sense.
    function automatic logic parity_mismatch(input logic acc, input logic sense);
        return acc ^ sense;
    endfunction

endpackage

// File: rtl/xor_parity_acc.sv
// Running XOR accumulator with synchronous clear and enable; shared by the
// receive checker and the transmit parity generator.
module xor_parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);
    import serial_parity_pkg::*;

    logic acc_r;

    // Accumulator register: clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 1'b0;
        end else if (clr) begin
            acc_r <= 1'b0;
        end else if (en) begin
            acc_r <= xor_step(acc_r, bit_in);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/serial_parity_rx.sv
// Bit-serial frame receiver: start/data/parity/stop deserialisation with parity
// and framing checks, delivering words through a valid/ready holding register.
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);
    import serial_parity_pkg::*;

    localparam int              CNT_W     = $clog2(DATA_W);
    localparam logic            PAR_SENSE = (PARITY_ODD != 0) ? serial_parity_pkg::PARITY_ODD : PARITY_EVEN;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] data_out_r;
    logic              valid_r;
    logic              perr_r;
    logic              ferr_r;
    logic              overrun_r;

    logic acc_s;
    logic acc_clr_s;
    logic acc_en_s;
    logic done_s;
    logic load_s;
    logic drop_s;
    logic perr_s;
    logic ferr_s;

    assign acc_clr_s = rx_en && (state_r == ST_IDLE) && (rx_bit == START_BIT);
    assign acc_en_s  = rx_en && ((state_r == ST_DATA) || (state_r == ST_PARITY));
    assign done_s    = rx_en && (state_r == ST_STOP);
    // A held word that is handed off on this same edge makes room for the new one.
    assign load_s    = done_s && (!valid_r || data_ready);
    assign drop_s    = done_s && valid_r && !data_ready;
    assign perr_s    = parity_mismatch(acc_s, PAR_SENSE);
    assign ferr_s    = (rx_bit != STOP_BIT);

    xor_parity_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr_s),
        .en     (acc_en_s),
        .bit_in (rx_bit),
        .acc    (acc_s)
    );

    // Frame FSM with bit counter and shift register; advances only on sample strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= {CNT_W{1'b0}};
            shift_r   <= {DATA_W{1'b0}};
        end else if (rx_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_bit == START_BIT) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_r <= {rx_bit, shift_r[DATA_W-1:1]};
                    if (bit_cnt_r == LAST_BIT) begin
                        state_r   <= ST_PARITY;
                        bit_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    state_r <= ST_STOP;
                end
                ST_STOP: begin
                    state_r <= ferr_s ? ST_WAIT_IDLE : ST_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (rx_bit == IDLE_LEVEL) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Output holding register and overrun pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r <= {DATA_W{1'b0}};
            valid_r    <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            overrun_r <= drop_s;
            if (load_s) begin
                data_out_r <= shift_r;
                perr_r     <= perr_s;
                ferr_r     <= ferr_s;
                valid_r    <= 1'b1;
            end else if (valid_r && data_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = valid_r;
    assign parity_err = perr_r;
    assign frame_err  = ferr_r;
    assign overrun    = overrun_r;

endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Bit-serial frame receiver with XOR parity checking. It deserializes start/data/parity/stop frames, qualified by a per-bit sample strobe, into parallel words. It flags parity and framing errors and presents each word on a valid/ready output holding register. It is the receive end of the team's parity-protected serial link and sits between the line-sampling logic and the consuming datapath.

## Interface
- DATA_W, 8: data bits per frame, ≥2
- PARITY_ODD, 0: 0 = even parity (XOR of data and parity bit must be 0), 1 = odd (must be 1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rx_en  in  1  sample strobe; rx_bit is consumed only in cycles with rx_en=1
- rx_bit  in  1  serial line value; idle is 1
- data_out  out  DATA_W  received word, LSB = first data bit received
- data_valid  out  1  data_out and its flags are held valid
- data_ready  in  1  consumer accepts the word when data_valid && data_ready
- parity_err  out  1  parity mismatch for the word on data_out; qualified by data_valid
- frame_err  out  1  stop bit sampled as 0 for the word on data_out; qualified by data_valid
- overrun  out  1  one-cycle pulse: a completed frame was dropped

## Operation
- Frame on sampled bits: start (0), DATA_W data bits LSB first, 1 parity bit, stop (1).
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE. All transitions happen only on rx_en=1 cycles.
- IDLE: rx_bit=0 → DATA. Clear the bit counter and the parity accumulator. rx_bit=1 → stay.
- DATA: shift rx_bit into the shift register MSB, shifting right. XOR rx_bit into the accumulator. After DATA_W bits → PARITY.
- PARITY: XOR rx_bit into the accumulator. → STOP.
- STOP: the frame completes in this cycle.
  - Accumulator ≠ PARITY_ODD → parity_err=1.
  - rx_bit=0 → frame_err=1, next state WAIT_IDLE.
  - rx_bit=1 → next state IDLE.
- WAIT_IDLE: stay until a sampled rx_bit=1, then → IDLE. This prevents a low line from being taken as a start bit.
- Completion load: the holding register loads the word and both error flags, and sets data_valid, if either of these holds in the completion cycle:
  - data_valid=0, or
  - data_valid && data_ready (the old word hands off and the new word loads in the same edge; no overrun).
- Otherwise the new frame is discarded, overrun pulses, and the held word and flags are unchanged.
- data_valid && data_ready with no completion in that cycle → data_valid clears on the next edge.
- Errored words are still delivered. The consumer drops them based on the flags.

## Timing
- Reset (async assert, state cleared immediately):
  - FSM = IDLE; shift register, counter and accumulator = 0.
  - data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, overrun = 0.
- Reset mid-frame abandons the partial frame. No output is produced for it.
- Latency: data_valid rises the cycle after the clk edge that samples the stop bit.
- overrun is high for exactly the cycle after the dropped completion.
- rx_en gaps of any length inside a frame are legal. The state holds across them.
- data_out and the flags are stable while data_valid=1 and data_ready=0.
- Back-to-back frames are supported. A start bit may be sampled on the very next rx_en after a good stop bit.

## Structure
- Shared package serial_parity_pkg:
  - FSM state enum
  - PARITY_EVEN/PARITY_ODD constants
  - frame-field order constants, shared with the transmit end
- Sub-module xor_parity_acc: running XOR with clear and enable. It is reused unchanged by the transmitter's parity generator.
- The FSM, counter, shift register and holding register live in the top module.

## Test plan
All scenarios use DATA_W=8 and even parity unless stated.
- Send 0xA5 as start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1, with data_ready=1 → one data_valid cycle, data_out=0xA5, parity_err=0, frame_err=0.
- Send 0x01 with parity bit 0 → data_out=0x01, parity_err=1. With PARITY_ODD=1 and parity bit 0 → parity_err=0.
- Send 0x3C with stop bit 0, then hold rx_bit=0 for 5 strobes, then 1, then a valid 0x7E frame:
  - first word: 0x3C with frame_err=1;
  - no spurious frames while the line is held low;
  - then 0x7E with no error flags.
- Hold data_ready=0 and send 0x11 then 0x22 → data_out stays 0x11, overrun pulses once. Raise data_ready → 0x11 accepted, and 0x22 never appears.
- Raise data_ready on the exact completion cycle of a second frame 0x55 while 0x44 is held → 0x44 accepted, 0x55 valid next cycle, overrun=0.
- Assert rst_n=0 after 4 data bits, then release and send 0x9C → all outputs 0 during reset, then only 0x9C is delivered.
